// File: rtl/pmod_jstk_reader.sv
// pmod_jstk_reader
//   Polls a PmodJSTK joystick over SPI mode 0 every POLL_CYCLES clocks and
//   presents the latest 10-bit X/Y position and the three buttons.
//
//   Ports
//     clk       system clock, rising edge
//     clr       asynchronous active-high reset
//     en        polling enable (sampled only when a poll slot comes round)
//     leds      LED request bits sent in byte 0 (only with JSTK_LED_EN)
//     miso      serial data from the joystick
//     ss        slave select, active-low
//     sclk      SPI clock, idle low
//     mosi      serial data to the joystick
//     joy_x     last X sample, 0..1023 (512 after reset)
//     joy_y     last Y sample, 0..1023 (512 after reset)
//     buttons   {trigger, btn2, btn1}, active-high
//     valid     one-cycle pulse coinciding with refreshed joy_x/joy_y/buttons
//     busy      high while a transaction is in progress
//
//   Build option
//     JSTK_LED_EN  when defined, byte 0 on mosi is {1'b1, 5'b0, leds} with
//                  leds captured at SETUP entry; otherwise mosi stays 0.
module pmod_jstk_reader #(
    parameter int unsigned SCLK_HALF   = 50,
    parameter int unsigned SS_SETUP    = 1500,
    parameter int unsigned BYTE_GAP    = 1000,
    parameter int unsigned POLL_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] leds,
    input  logic       miso,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    output logic [9:0] joy_x,
    output logic [9:0] joy_y,
    output logic [2:0] buttons,
    output logic       valid,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;

    localparam int unsigned TMAX_A = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
    localparam int unsigned TMAX   = (TMAX_A > SCLK_HALF) ? TMAX_A : SCLK_HALF;
    localparam int unsigned TW     = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned PW     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [TW-1:0] SETUP_LAST = TW'(SS_SETUP - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(SCLK_HALF - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(BYTE_GAP - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic          sclk_q, sclk_d;
    logic          ss_q, ss_d;
    logic [7:0]    rx_q, rx_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [9:0]    joy_x_q, joy_x_d;
    logic [9:0]    joy_y_q, joy_y_d;
    logic [2:0]    btn_q, btn_d;
    logic          valid_q, valid_d;
`ifdef JSTK_LED_EN
    logic [7:0]    tx_q, tx_d;
    logic          mosi_q, mosi_d;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            poll_q  <= '0;
            tmr_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sclk_q  <= 1'b0;
            ss_q    <= 1'b1;
            rx_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            joy_x_q <= 10'd512;
            joy_y_q <= 10'd512;
            btn_q   <= '0;
            valid_q <= 1'b0;
`ifdef JSTK_LED_EN
            tx_q    <= '0;
            mosi_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sclk_q  <= sclk_d;
            ss_q    <= ss_d;
            rx_q    <= rx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            joy_x_q <= joy_x_d;
            joy_y_q <= joy_y_d;
            btn_q   <= btn_d;
            valid_q <= valid_d;
`ifdef JSTK_LED_EN
            tx_q    <= tx_d;
            mosi_q  <= mosi_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sclk_d  = sclk_q;
        ss_d    = ss_q;
        rx_d    = rx_q;
        x_d     = x_q;
        y_d     = y_q;
        joy_x_d = joy_x_q;
        joy_y_d = joy_y_q;
        btn_d   = btn_q;
        valid_d = 1'b0;
`ifdef JSTK_LED_EN
        tx_d    = tx_q;
        mosi_d  = mosi_q;
`endif
        // The poll counter runs through transactions so start-to-start is fixed.
        poll_d = (poll_q == POLL_LAST) ? '0 : poll_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (poll_q == POLL_LAST && en) begin
                    state_d = SETUP;
                    tmr_d   = '0;
                    ss_d    = 1'b0;
`ifdef JSTK_LED_EN
                    tx_d    = {1'b1, 5'b0, leds};
`endif
                end
            end
            SETUP: begin
                if (tmr_q == SETUP_LAST) begin
                    state_d = SHIFT;
                    tmr_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
`ifdef JSTK_LED_EN
                    mosi_d  = tx_q[7];
`endif
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            SHIFT: begin
                if (tmr_q == HALF_LAST) begin
                    tmr_d = '0;
                    if (!sclk_q) begin
                        // miso sampled on the same edge that raises sclk
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            unique case (byte_q)
                                3'd0:    x_d[7:0] = rx_q;
                                3'd1:    x_d[9:8] = rx_q[1:0];
                                3'd2:    y_d[7:0] = rx_q;
                                3'd3:    y_d[9:8] = rx_q[1:0];
                                default: ;
                            endcase
                            state_d = (byte_q == 3'd4) ? DONE : GAP;
`ifdef JSTK_LED_EN
                            tx_d    = '0;
                            mosi_d  = 1'b0;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
`ifdef JSTK_LED_EN
                            tx_d   = {tx_q[6:0], 1'b0};
                            mosi_d = tx_q[6];
`endif
                        end
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            GAP: begin
                if (tmr_q == GAP_LAST) begin
                    state_d = SHIFT;
                    tmr_d   = '0;
                    bit_d   = '0;
                    byte_d  = byte_q + 1'b1;
`ifdef JSTK_LED_EN
                    mosi_d  = tx_q[7];
`endif
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            DONE: begin
                // Byte 4 is still in rx_q; outputs and valid update together.
                state_d = IDLE;
                ss_d    = 1'b1;
                joy_x_d = x_q;
                joy_y_d = y_q;
                btn_d   = rx_q[2:0];
                valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ss      = ss_q;
    assign sclk    = sclk_q;
    assign busy    = ~ss_q;
    assign joy_x   = joy_x_q;
    assign joy_y   = joy_y_q;
    assign buttons = btn_q;
    assign valid   = valid_q;

`ifdef JSTK_LED_EN
    assign mosi = mosi_q;
`else
    logic unused_leds;
    assign unused_leds = ^leds;
    assign mosi        = 1'b0;
`endif

endmodule

// File: tb/tb_pmod_jstk_reader.sv
// tb_pmod_jstk_reader
//   Directed bench for pmod_jstk_reader with small timing parameters.
//   A joystick model loads a 40-bit response frame on ss falling and shifts
//   it out on sclk falling edges; a monitor measures ss width, sclk edges,
//   poll spacing, valid pulses and captures mosi on sclk rising edges.
module tb_pmod_jstk_reader;

    localparam int unsigned HALF  = 2;
    localparam int unsigned SETUP = 10;
    localparam int unsigned GAPC  = 6;
    localparam int unsigned POLL  = 400;

    // X=0x2A5, Y=0x0F3, buttons=101, junk in the ignored upper bits
    localparam logic [39:0] FRAME_A = {8'hA5, 8'hFE, 8'hF3, 8'hFC, 8'hFD};
    // X low 0xFF with all upper bits set -> 1023; Y=0; buttons=010
    localparam logic [39:0] FRAME_B = {8'hFF, 8'hFF, 8'h00, 8'hFC, 8'hFA};

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic [1:0] leds;
    logic       miso = 1'b0;
    logic       ss, sclk, mosi, valid, busy;
    logic [9:0] joy_x, joy_y;
    logic [2:0] buttons;

    pmod_jstk_reader #(
        .SCLK_HALF   (HALF),
        .SS_SETUP    (SETUP),
        .BYTE_GAP    (GAPC),
        .POLL_CYCLES (POLL)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .leds    (leds),
        .miso    (miso),
        .ss      (ss),
        .sclk    (sclk),
        .mosi    (mosi),
        .joy_x   (joy_x),
        .joy_y   (joy_y),
        .buttons (buttons),
        .valid   (valid),
        .busy    (busy)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor / joystick model state
    logic [39:0] frame = FRAME_A;
    logic [39:0] shreg = '0;
    logic [39:0] mosi_cap = '0;
    logic        ss_prev = 1'b1, sclk_prev = 1'b0, valid_prev = 1'b0;
    logic        mosi_prev = 1'b0, clr_prev = 1'b1;
    logic [22:0] joy_prev = '0;
    int n_starts = 0, start_cyc = 0, start_prev = 0;
    int low_cnt = 0, last_low = 0, rises = 0;
    int vcyc = 0, vpulses = 0;
    int sclk_viol = 0, mosi_viol = 0, stab_viol = 0;

    always @(negedge clk) begin
        ss_prev    <= ss;
        sclk_prev  <= sclk;
        valid_prev <= valid;
        mosi_prev  <= mosi;
        clr_prev   <= clr;
        joy_prev   <= {joy_x, joy_y, buttons};
        if (ss_prev && !ss) begin
            n_starts   <= n_starts + 1;
            start_prev <= start_cyc;
            start_cyc  <= cyc;
            low_cnt    <= 1;
            rises      <= 0;
            mosi_cap   <= '0;
            shreg      <= frame;
            miso       <= frame[39];
        end else begin
            if (!ss) low_cnt <= low_cnt + 1;
            if (!ss_prev && ss) last_low <= low_cnt;
            if (sclk && !sclk_prev) begin
                rises    <= rises + 1;
                mosi_cap <= {mosi_cap[38:0], mosi};
            end
            if (!sclk && sclk_prev && !ss) begin
                shreg <= {shreg[38:0], 1'b0};
                miso  <= shreg[38];
            end
        end
        if (valid) vcyc <= vcyc + 1;
        if (valid && !valid_prev) vpulses <= vpulses + 1;
        if (ss && sclk) sclk_viol <= sclk_viol + 1;
        if (mosi !== mosi_prev && sclk) mosi_viol <= mosi_viol + 1;
        if (!clr && !clr_prev && !valid && ({joy_x, joy_y, buttons} !== joy_prev))
            stab_viol <= stab_viol + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_start(input int bound, input string tag);
        int  s0;
        logic ok;
        s0 = n_starts;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick(1);
            if (n_starts != s0) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 40'(ok), 40'd1);
    endtask

    task automatic wait_valid(input int bound, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick(1);
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 40'(ok), 40'd1);
    endtask

    task automatic wait_rises(input int n, input int bound, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick(1);
            if (rises >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 40'(ok), 40'd1);
    endtask

    logic [39:0] exp_mosi;
    int c_rel, vp0, vc0, s0;

    initial begin
`ifdef JSTK_LED_EN
        exp_mosi = {8'h82, 32'h0};
`else
        exp_mosi = '0;
`endif
        clr  = 1'b1;
        en   = 1'b0;
        leds = 2'b10;
        tick(3);
        check("rst_ss",      40'(ss),      40'd1);
        check("rst_sclk",    40'(sclk),    40'd0);
        check("rst_mosi",    40'(mosi),    40'd0);
        check("rst_busy",    40'(busy),    40'd0);
        check("rst_valid",   40'(valid),   40'd0);
        check("rst_joy_x",   40'(joy_x),   40'd512);
        check("rst_joy_y",   40'(joy_y),   40'd512);
        check("rst_buttons", 40'(buttons), 40'd0);

        // transaction 1: nominal data, first start POLL cycles after release
        clr   = 1'b0;
        en    = 1'b1;
        c_rel = cyc;
        wait_start(POLL + 100, "start1_seen");
        check("start1_delay", 40'(start_cyc - c_rel), 40'(POLL));
        check("start1_busy",  40'(busy), 40'd1);
        vp0 = vpulses;
        vc0 = vcyc;
        wait_valid(400, "valid1_seen");
        check("t1_joy_x",   40'(joy_x),   40'd677);
        check("t1_joy_y",   40'(joy_y),   40'd243);
        check("t1_buttons", 40'(buttons), 40'd5);
        check("t1_busy",    40'(busy),    40'd0);
        check("t1_ss_len",  40'(last_low), 40'(SETUP + 80 * HALF + 4 * GAPC + 1));
        check("t1_rises",   40'(rises),   40'd40);
        check("t1_mosi",    mosi_cap,     exp_mosi);
        frame = FRAME_B;
        tick(1);
        check("t1_valid_drop", 40'(valid), 40'd0);
        check("t1_vpulses",    40'(vpulses - vp0), 40'd1);
        check("t1_vcycles",    40'(vcyc - vc0),    40'd1);

        // transaction 2: saturated X with junk upper bits; en drops in byte 2
        wait_start(POLL, "start2_seen");
        check("start2_period", 40'(start_cyc - start_prev), 40'(POLL));
        wait_rises(17, 400, "t2_byte2_seen");
        en = 1'b0;
        wait_valid(400, "valid2_seen");
        check("t2_joy_x",   40'(joy_x),   40'd1023);
        check("t2_joy_y",   40'(joy_y),   40'd0);
        check("t2_buttons", 40'(buttons), 40'd2);
        check("t2_rises",   40'(rises),   40'd40);
        s0  = n_starts;
        vp0 = vpulses;
        tick(900);
        check("en_low_no_start", 40'(n_starts - s0), 40'd0);
        check("en_low_no_valid", 40'(vpulses - vp0), 40'd0);
        check("en_low_ss",       40'(ss),            40'd1);

        // transaction 3: aborted by clr at the 20th sclk rise
        en = 1'b1;
        wait_start(POLL + 100, "start3_seen");
        wait_rises(20, 400, "t3_rise20_seen");
        check("t3_sclk_hi", 40'(sclk), 40'd1);
        clr = 1'b1;
        #1;
        check("abort_ss",    40'(ss),    40'd1);
        check("abort_sclk",  40'(sclk),  40'd0);
        check("abort_joy_x", 40'(joy_x), 40'd512);
        check("abort_valid", 40'(valid), 40'd0);
        check("abort_busy",  40'(busy),  40'd0);
        vp0   = vpulses;
        frame = FRAME_A;
        tick(2);
        clr   = 1'b0;
        c_rel = cyc;
        wait_start(POLL + 100, "start4_seen");
        check("restart_delay",     40'(start_cyc - c_rel), 40'(POLL));
        check("abort_no_valid",    40'(vpulses - vp0),     40'd0);
        check("restart_joy_y",     40'(joy_y),             40'd512);
        wait_valid(400, "valid4_seen");
        check("t4_joy_x",   40'(joy_x),   40'd677);
        check("t4_joy_y",   40'(joy_y),   40'd243);
        check("t4_buttons", 40'(buttons), 40'd5);
        check("t4_mosi",    mosi_cap,     exp_mosi);
        tick(2);

        check("sclk_while_ss_high", 40'(sclk_viol), 40'd0);
        check("mosi_while_sclk_hi", 40'(mosi_viol), 40'd0);
        check("outputs_stable",     40'(stab_viol), 40'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pmod_jstk_reader.md
PMOD_JSTK_READER -- requirements
Module: pmod_jstk_reader

Interface
REQ-001 SHALL have parameter SCLK_HALF, default 50: clk cycles per SCLK half-period (1 MHz at 100 MHz clk).
REQ-002 SHALL have parameter SS_SETUP, default 1500: clk cycles from ss falling to the first SCLK low phase (15 us).
REQ-003 SHALL have parameter BYTE_GAP, default 1000: idle clk cycles between bytes, with SCLK held low (10 us).
REQ-004 SHALL have parameter POLL_CYCLES, default 1000000: clk cycles from transaction start to the next transaction start (10 ms).
REQ-005 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-006 SHALL have port clr, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port en, input, 1: polling enable.
REQ-008 SHALL have port leds, input, 2: joystick LED request bits.
REQ-009 SHALL have port miso, input, 1: serial data from the joystick.
REQ-010 SHALL have port ss, output, 1: slave select, active-low.
REQ-011 SHALL have port sclk, output, 1: SPI clock, mode 0 (idle low).
REQ-012 SHALL have port mosi, output, 1: serial data to the joystick.
REQ-013 SHALL have port joy_x, output, 10: last X sample (0..1023).
REQ-014 SHALL have port joy_y, output, 10: last Y sample (0..1023).
REQ-015 SHALL have port buttons, output, 3: {trigger, btn2, btn1}, active-high.
REQ-016 SHALL have port valid, output, 1: one-cycle pulse when outputs are refreshed.
REQ-017 SHALL have port busy, output, 1: high while a transaction is in progress.

Function
REQ-018 SHALL implement states IDLE, SETUP, SHIFT, GAP and DONE.
REQ-019 IDLE: poll counter SHALL free-run modulo POLL_CYCLES; at terminal count with en=1 -> SETUP, ss=0, busy=1.
REQ-020 SETUP SHALL last SS_SETUP cycles, then -> SHIFT for byte 0.
REQ-021 SHIFT: each bit SHALL be SCLK_HALF cycles low then SCLK_HALF cycles high; 8 bits per byte, MSB first.
REQ-022 mosi SHALL change only while sclk is low: bit 7 on SHIFT entry, later bits on the sclk falling edge.
REQ-023 miso SHALL be sampled on the same clk edge that drives sclk high.
REQ-024 After the 8th bit's high phase, sclk SHALL return low; bytes 0-3 -> GAP for BYTE_GAP cycles, then -> SHIFT; byte 4 -> DONE.
REQ-025 Received byte order SHALL be: X[7:0], {6'bx, X[9:8]}, Y[7:0], {6'bx, Y[9:8]}, {5'bx, buttons}; bits marked x ignored.
REQ-026 DONE (one cycle) SHALL set ss=1, busy=0, load joy_x/joy_y/buttons, pulse valid, then -> IDLE.
REQ-027 joy_x, joy_y and buttons SHALL hold stable between valid pulses; partial bytes SHALL never appear on them.
REQ-028 Transaction length SHALL be SS_SETUP + 40*2*SCLK_HALF + 4*BYTE_GAP + 1 cycles; POLL_CYCLES SHALL exceed this length, which is not checked in RTL.
REQ-029 en falling mid-transaction SHALL NOT abort it; the transaction completes normally.
REQ-030 sclk SHALL be 0 whenever ss=1.

Reset
REQ-031 clr=1 SHALL immediately force ss=1, sclk=0, mosi=0, busy=0, valid=0, joy_x=512, joy_y=512, buttons=0, state IDLE, poll counter 0; 512 is joystick centre (consumer dead zone).
REQ-032 clr asserted mid-transaction SHALL discard all partial data; the first transaction after release starts POLL_CYCLES cycles later if en=1.

Configuration
REQ-033 With JSTK_LED_EN defined, byte 0 on mosi SHALL be {1'b1, 5'b0, leds} and bytes 1-4 SHALL be 0x00; leds SHALL be sampled at SETUP entry.
REQ-034 Without JSTK_LED_EN, mosi SHALL be constant 0 and leds SHALL be ignored; the leds port remains present.

Verification
REQ-035 Joystick model returns X=0x2A5, Y=0x0F3, buttons=3'b101 -> after one transaction joy_x=677, joy_y=243, buttons=5, valid high exactly 1 cycle.
REQ-036 Small parameters (SCLK_HALF=2, SS_SETUP=10, BYTE_GAP=6, POLL=400) -> ss low exactly 195 cycles, 40 sclk rising edges, start-to-start 400 cycles.
REQ-037 Assert clr at the 20th sclk rise -> ss=1 and sclk=0 next cycle, joy_x=512, no valid pulse, next transaction 400 cycles after clr release.
REQ-038 en=0 held -> ss stays 1 indefinitely; drop en during byte 2 -> transaction completes with valid pulse, no further ss assertion.
REQ-039 JSTK_LED_EN defined, leds=2'b10 -> mosi byte 0 = 0x82, bytes 1-4 = 0x00; macro undefined -> mosi=0 throughout.
REQ-040 Model drives upper bits of bytes 1/3 as 0xFC, X low byte=0xFF -> joy_x=1023, upper bits ignored, no overflow.
